// File: rtl/cmp_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : cmp_arbiter
// Description : Round-robin share of one WIDTH-bit comparator between two
//               requesters, with a one-entry valid/ready response buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module cmp_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [2:0]       req0_func,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [2:0]       req1_func,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic             resp_id,
    output logic             resp_result
);

    logic             last_grant;
    logic             can_accept;
    logic             grant_any;
    logic             grant_id;
    logic             accept;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;
    logic [2:0]       sel_func;
    logic             cmp_result;

    // func[2]=less, func[1]=signed (only meaningful with less), func[0]=negate
    function automatic logic compare(input logic [WIDTH-1:0] a,
                                     input logic [WIDTH-1:0] b,
                                     input logic [2:0]       func);
        logic base;
        if (func[2]) begin
            if (func[1]) base = ($signed(a) < $signed(b));
            else         base = (a < b);
        end else begin
            base = (a == b);
        end
        return base ^ func[0];
    endfunction

    always_comb begin
        can_accept = !flush && (!resp_valid || resp_ready);
        grant_any  = req0_valid || req1_valid;
        if (req0_valid && req1_valid) grant_id = ~last_grant;
        else if (req0_valid)          grant_id = 1'b0;
        else                          grant_id = 1'b1;
        accept     = reset_n && can_accept && grant_any;
        req0_ready = accept && !grant_id;
        req1_ready = accept && grant_id;
    end

    always_comb begin
        sel_a      = grant_id ? req1_a    : req0_a;
        sel_b      = grant_id ? req1_b    : req0_b;
        sel_func   = grant_id ? req1_func : req0_func;
        cmp_result = compare(sel_a, sel_b, sel_func);
    end

    // Reset leaves last_grant=1 so port 0 wins the first contested cycle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            resp_valid  <= 1'b0;
            resp_id     <= 1'b0;
            resp_result <= 1'b0;
            last_grant  <= 1'b1;
        end else if (accept) begin
            resp_valid  <= 1'b1;
            resp_id     <= grant_id;
            resp_result <= cmp_result;
            last_grant  <= grant_id;
        end else if (flush || resp_ready) begin
            resp_valid  <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cmp_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_cmp_arbiter
// Description : Directed scoreboard bench for cmp_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cmp_arbiter;

    localparam int WIDTH = 32;

    logic             clk;
    logic             reset_n;
    logic             flush;
    logic             req0_valid;
    logic             req0_ready;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic [2:0]       req0_func;
    logic             req1_valid;
    logic             req1_ready;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic [2:0]       req1_func;
    logic             resp_valid;
    logic             resp_ready;
    logic             resp_id;
    logic             resp_result;

    int checks = 0;
    int errors = 0;

    logic [1:0] sb[$];
    logic [1:0] mon_exp;
    logic [1:0] mon_drop;
    logic       s_valid;
    logic       s_id;
    logic       s_res;

    cmp_arbiter #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .flush      (flush),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_func  (req0_func),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_func  (req1_func),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_id    (resp_id),
        .resp_result(resp_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%b expected=%b", nm, act, exp);
        end
    endtask

    // One cycle: sample at negedge, check grants, queue the expected responses
    task automatic tick(input logic er0, input logic er1,
                        input logic x0, input logic x1, input string nm);
        @(negedge clk);
        s_valid = resp_valid;
        s_id    = resp_id;
        s_res   = resp_result;
        chk({nm, "/req0_ready"}, req0_ready, er0);
        chk({nm, "/req1_ready"}, req1_ready, er1);
        if (er0) sb.push_back({1'b0, x0});
        if (er1) sb.push_back({1'b1, x1});
        @(posedge clk);
        #1;
    endtask

    // A flushed response is dropped from the scoreboard, never delivered
    always @(negedge clk) begin
        if (reset_n && resp_valid) begin
            if (flush) begin
                if (sb.size() > 0) mon_drop = sb.pop_front();
            end else if (resp_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL resp_unexpected got id=%b res=%b expected=none",
                             resp_id, resp_result);
                end else begin
                    mon_exp = sb.pop_front();
                    if ({resp_id, resp_result} !== mon_exp) begin
                        errors++;
                        $display("FAIL resp got id=%b res=%b expected id=%b res=%b",
                                 resp_id, resp_result, mon_exp[1], mon_exp[0]);
                    end
                end
            end
        end
    end

    initial begin
        reset_n = 1'b0; flush = 1'b0; resp_ready = 1'b1;
        req0_valid = 1'b1; req0_a = '0; req0_b = '0; req0_func = 3'b000;
        req1_valid = 1'b1; req1_a = '0; req1_b = '0; req1_func = 3'b000;
        #3;
        chk("reset/resp_valid",  resp_valid,  1'b0);
        chk("reset/resp_id",     resp_id,     1'b0);
        chk("reset/resp_result", resp_result, 1'b0);
        chk("reset/req0_ready",  req0_ready,  1'b0);
        chk("reset/req1_ready",  req1_ready,  1'b0);
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;

        // Single EQ request from port 0
        req0_valid = 1'b1; req0_a = 32'd5; req0_b = 32'd5; req0_func = 3'b000;
        tick(1'b1, 1'b0, 1'b1, 1'b0, "single");

        // Contention: port 1 first since port 0 was granted last
        req0_a = 32'hFFFF_FFFF; req0_b = 32'd1; req0_func = 3'b110;
        req1_valid = 1'b1;
        req1_a = 32'hFFFF_FFFF; req1_b = 32'd1; req1_func = 3'b100;
        tick(1'b0, 1'b1, 1'b0, 1'b0, "rr0");
        chk("rr0/resp_valid", s_valid, 1'b1);
        tick(1'b1, 1'b0, 1'b1, 1'b0, "rr1");
        tick(1'b0, 1'b1, 1'b0, 1'b0, "rr2");
        tick(1'b1, 1'b0, 1'b1, 1'b0, "rr3");

        // Back-pressure: response result=1 held while port 1 waits
        req1_valid = 1'b0;
        tick(1'b1, 1'b0, 1'b1, 1'b0, "bp_fill");
        req0_valid = 1'b0; req1_valid = 1'b1; resp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, 1'b0, 1'b0, 1'b0, "bp_hold");
            chk("bp_hold/resp_valid",  s_valid, 1'b1);
            chk("bp_hold/resp_id",     s_id,    1'b0);
            chk("bp_hold/resp_result", s_res,   1'b1);
        end
        resp_ready = 1'b1;
        tick(1'b0, 1'b1, 1'b0, 1'b0, "bp_release");
        req1_valid = 1'b0;
        tick(1'b0, 1'b0, 1'b0, 1'b0, "bp_next");
        chk("bp_next/resp_valid", s_valid, 1'b1);
        chk("bp_next/resp_id",    s_id,    1'b1);

        // Flush with a buffered response and both ports waiting
        req0_valid = 1'b1; req0_a = 32'h8000_0000; req0_b = 32'h7FFF_FFFF; req0_func = 3'b000;
        req1_a = 32'd5; req1_b = 32'd5; req1_func = 3'b000;
        resp_ready = 1'b0;
        tick(1'b1, 1'b0, 1'b0, 1'b0, "fl_fill");
        req1_valid = 1'b1; resp_ready = 1'b1; flush = 1'b1;
        tick(1'b0, 1'b0, 1'b0, 1'b0, "fl_cycle");
        chk("fl_cycle/resp_valid", s_valid, 1'b1);
        flush = 1'b0;
        tick(1'b0, 1'b1, 1'b0, 1'b1, "fl_after");
        chk("fl_after/resp_valid", s_valid, 1'b0);
        req1_valid = 1'b0;
        tick(1'b1, 1'b0, 1'b0, 1'b0, "fl_req0");
        req0_valid = 1'b0;
        tick(1'b0, 1'b0, 1'b0, 1'b0, "fl_drain");

        // Function sweep on port 0, continuous valid
        req0_valid = 1'b1;
        begin
            logic [2:0] funcs [8] = '{3'b000, 3'b001, 3'b100, 3'b101,
                                      3'b110, 3'b111, 3'b010, 3'b011};
            logic       exps  [8] = '{1'b0, 1'b1, 1'b0, 1'b1,
                                      1'b1, 1'b0, 1'b0, 1'b1};
            for (int i = 0; i < 8; i++) begin
                req0_func = funcs[i];
                tick(1'b1, 1'b0, exps[i], 1'b0, $sformatf("sweep%0d", i));
            end
        end
        req0_valid = 1'b0;
        tick(1'b0, 1'b0, 1'b0, 1'b0, "sweep_drain");

        // Asynchronous reset while a response is buffered
        req0_valid = 1'b1; req0_a = 32'd5; req0_b = 32'd5; req0_func = 3'b000;
        resp_ready = 1'b0;
        tick(1'b1, 1'b0, 1'b1, 1'b0, "rst_fill");
        req0_valid = 1'b0;
        chk("rst_pre/resp_valid", resp_valid, 1'b1);
        #2;
        reset_n = 1'b0;
        sb.delete();
        #1;
        chk("rst_async/resp_valid", resp_valid, 1'b0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        resp_ready = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b1;
        req1_a = 32'd5; req1_b = 32'd5; req1_func = 3'b001;
        tick(1'b1, 1'b0, 1'b1, 1'b0, "rst_first");
        tick(1'b0, 1'b1, 1'b0, 1'b0, "rst_second");
        req0_valid = 1'b0; req1_valid = 1'b0;
        tick(1'b0, 1'b0, 1'b0, 1'b0, "end0");
        tick(1'b0, 1'b0, 1'b0, 1'b0, "end1");

        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_empty got=%0d pending expected=0", sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
